// File: rtl/ledcube_i2c_pkg.sv
// Shared types and constants for the LED-cube I2C register target.
// Read support in the target is enabled by defining LEDCUBE_I2C_TARGET_READ_EN.
package ledcube_i2c_pkg;

   localparam int unsigned I2C_ADDR_W = 7;

   // Open-drain levels as seen on SDA during an acknowledge slot.
   localparam logic SDA_ACK  = 1'b0;
   localparam logic SDA_NACK = 1'b1;

   typedef enum logic [3:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StReg,
      StRegAck,
      StWdata,
      StWdataAck,
      StRdata,
      StRdataAck,
      StIgnore
   } state_e;

endpackage

// File: rtl/ledcube_i2c_sync.sv
// Two-flop synchronizer for SCL/SDA plus edge, START and STOP detection.
// Every event is derived from synchronized samples only.
module ledcube_i2c_sync (
   input  logic clock,
   input  logic reset,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   // [1:0] is the synchronizer chain, [2] holds the previous synchronized value.
   logic [2:0] scl_q;
   logic [2:0] sda_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scl_q <= '1;
         sda_q <= '1;
      end else begin
         scl_q <= {scl_q[1:0], scl_i};
         sda_q <= {sda_q[1:0], sda_i};
      end
   end

   assign sda_o      = sda_q[1];
   assign scl_rise_o = scl_q[1] & ~scl_q[2];
   assign scl_fall_o = ~scl_q[1] & scl_q[2];
   assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
   assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/ledcube_i2c_target.sv
// I2C target exposing a byte-wide register file with an auto-incrementing pointer.
// Define LEDCUBE_I2C_TARGET_READ_EN to generate read-transfer support.
module ledcube_i2c_target
   import ledcube_i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] DEV_ADDR = 7'h20,
   parameter int unsigned           NUM_REGS = 32
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        sda_in,
   input  logic                        scl_in,
   output logic                        sda_out,
   output logic                        wr_valid,
   output logic [$clog2(NUM_REGS)-1:0] wr_addr,
   output logic [7:0]                  wr_data,
   input  logic [$clog2(NUM_REGS)-1:0] reg_rd_addr,
   output logic [7:0]                  reg_rd_data,
   output logic                        busy
);

   localparam int unsigned AW = $clog2(NUM_REGS);

   logic sda_s;
   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   ledcube_i2c_sync u_sync (
      .clock      (clock),
      .reset      (reset),
      .scl_i      (scl_in),
      .sda_i      (sda_in),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start_det),
      .stop_o     (stop_det)
   );

   state_e        state_q;
   logic [3:0]    bit_cnt_q;
   logic [7:0]    rx_q;
   logic [AW-1:0] ptr_q;
   logic [7:0]    regs_q [NUM_REGS];
   logic          sda_out_q;
   logic          wr_valid_q;
   logic [AW-1:0] wr_addr_q;
   logic [7:0]    wr_data_q;
   logic          busy_q;
   logic          addr_hit;
`ifdef LEDCUBE_I2C_TARGET_READ_EN
   logic [7:0]    tx_q;
   logic          rw_q;
   logic          mack_q;
`endif

   assign addr_hit = (rx_q[7:1] == DEV_ADDR);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         rx_q       <= '0;
         ptr_q      <= '0;
         sda_out_q  <= SDA_NACK;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         busy_q     <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef LEDCUBE_I2C_TARGET_READ_EN
         tx_q       <= '0;
         rw_q       <= 1'b0;
         mack_q     <= SDA_NACK;
`endif
      end else begin
         wr_valid_q <= 1'b0;
         if (start_det) begin
            state_q   <= StAddr;
            bit_cnt_q <= '0;
            sda_out_q <= SDA_NACK;
            busy_q    <= 1'b0;
         end else if (stop_det) begin
            state_q   <= StIdle;
            sda_out_q <= SDA_NACK;
            busy_q    <= 1'b0;
         end else if (scl_rise) begin
            case (state_q)
               StAddr, StReg, StWdata: begin
                  rx_q      <= {rx_q[6:0], sda_s};
                  bit_cnt_q <= bit_cnt_q + 4'd1;
               end
`ifdef LEDCUBE_I2C_TARGET_READ_EN
               StRdata:    bit_cnt_q <= bit_cnt_q + 4'd1;
               StRdataAck: mack_q    <= sda_s;
`endif
               default: ;
            endcase
         end else if (scl_fall) begin
            // All SDA changes happen here, while SCL is low.
            case (state_q)
               StAddr: begin
                  if (bit_cnt_q == 4'd8) begin
`ifdef LEDCUBE_I2C_TARGET_READ_EN
                     if (addr_hit) begin
                        rw_q <= rx_q[0];
`else
                     if (addr_hit && !rx_q[0]) begin
`endif
                        state_q   <= StAddrAck;
                        sda_out_q <= SDA_ACK;
                        busy_q    <= 1'b1;
                     end else begin
                        state_q <= StIgnore;
                     end
                  end
               end
               StAddrAck: begin
                  bit_cnt_q <= '0;
`ifdef LEDCUBE_I2C_TARGET_READ_EN
                  if (rw_q) begin
                     state_q   <= StRdata;
                     sda_out_q <= regs_q[ptr_q][7];
                     tx_q      <= {regs_q[ptr_q][6:0], 1'b0};
                     ptr_q     <= ptr_q + AW'(1);
                  end else begin
                     state_q   <= StReg;
                     sda_out_q <= SDA_NACK;
                  end
`else
                  state_q   <= StReg;
                  sda_out_q <= SDA_NACK;
`endif
               end
               StReg: begin
                  if (bit_cnt_q == 4'd8) begin
                     ptr_q     <= rx_q[AW-1:0];
                     sda_out_q <= SDA_ACK;
                     state_q   <= StRegAck;
                  end
               end
               StRegAck, StWdataAck: begin
                  bit_cnt_q <= '0;
                  sda_out_q <= SDA_NACK;
                  state_q   <= StWdata;
               end
               StWdata: begin
                  if (bit_cnt_q == 4'd8) begin
                     regs_q[ptr_q] <= rx_q;
                     wr_valid_q    <= 1'b1;
                     wr_addr_q     <= ptr_q;
                     wr_data_q     <= rx_q;
                     ptr_q         <= ptr_q + AW'(1);
                     sda_out_q     <= SDA_ACK;
                     state_q       <= StWdataAck;
                  end
               end
`ifdef LEDCUBE_I2C_TARGET_READ_EN
               StRdata: begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_out_q <= SDA_NACK;
                     state_q   <= StRdataAck;
                  end else begin
                     sda_out_q <= tx_q[7];
                     tx_q      <= {tx_q[6:0], 1'b0};
                  end
               end
               StRdataAck: begin
                  bit_cnt_q <= '0;
                  if (mack_q == SDA_ACK) begin
                     state_q   <= StRdata;
                     sda_out_q <= regs_q[ptr_q][7];
                     tx_q      <= {regs_q[ptr_q][6:0], 1'b0};
                     ptr_q     <= ptr_q + AW'(1);
                  end else begin
                     state_q   <= StIgnore;
                     sda_out_q <= SDA_NACK;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign sda_out     = sda_out_q;
   assign wr_valid    = wr_valid_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign busy        = busy_q;
   assign reg_rd_data = regs_q[reg_rd_addr];

endmodule

// File: tb/tb_ledcube_i2c_target.sv
// Bench for ledcube_i2c_target: bit-banged I2C initiator, register-file model and scoreboard.
// Read transfers are exercised when LEDCUBE_I2C_TARGET_READ_EN is defined.
module tb_ledcube_i2c_target;

   localparam int NREG = 32;
   localparam int Q    = 60;  // quarter SCL period; SCL period is 24 clocks
   localparam logic [6:0] DEV = 7'h20;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_out;
   logic       wr_valid;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic [4:0] reg_rd_addr = '0;
   logic [7:0] reg_rd_data;
   logic       busy;
   logic       bus_sda;

   assign bus_sda = sda_m & sda_out;

   ledcube_i2c_target dut (
      .clock       (clock),
      .reset       (reset),
      .sda_in      (bus_sda),
      .scl_in      (scl_m),
      .sda_out     (sda_out),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .reg_rd_addr (reg_rd_addr),
      .reg_rd_data (reg_rd_data),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [4:0] a;
      logic [7:0] d;
   } wr_t;

   int         tests = 0;
   int         fails = 0;
   bit         chk_en = 1'b0;
   logic [7:0] model_regs [NREG];
   int         model_ptr = 0;
   wr_t        exp_wr [$];
   logic [7:0] tx_bytes [$];
   logic [7:0] rx_bytes [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every write pulse must match the next expected write; the
   // register file must always agree with the model.
   always @(negedge clock) begin
      if (chk_en && !reset) begin
         if (wr_valid) begin
            tests++;
            if (exp_wr.size() == 0) begin
               fails++;
               $display("FAIL wr_unexpected: got write addr=%0d data=0x%0h, required none",
                        wr_addr, wr_data);
            end else begin
               wr_t e;
               e = exp_wr.pop_front();
               check("wr_addr", 32'(wr_addr), 32'(e.a));
               check("wr_data", 32'(wr_data), 32'(e.d));
               model_regs[e.a] = e.d;
            end
         end
         check("reg_rd_data", 32'(reg_rd_data), 32'(model_regs[reg_rd_addr]));
      end
   end

   task automatic clk_bit(input logic b, output logic rb);
      sda_m = b;
      #Q scl_m = 1'b1;
      #Q rb = bus_sda;
      #Q scl_m = 1'b0;
      #Q;
   endtask

   task automatic bus_start();
      sda_m = 1'b1;
      #Q scl_m = 1'b1;
      #Q sda_m = 1'b0;
      #Q scl_m = 1'b0;
      #Q;
   endtask

   task automatic bus_stop();
      sda_m = 1'b0;
      #Q scl_m = 1'b1;
      #Q sda_m = 1'b1;
      #Q;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
      logic       rb;
      logic [7:0] seen;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(b[i], rb);
         seen[i] = rb;
      end
      check({name, "_bits"}, 32'(seen), 32'(b));
      clk_bit(1'b1, rb);
      check({name, "_ack"}, 32'(rb), 32'(exp_ack));
   endtask

   task automatic recv_byte(input logic mack, output logic [7:0] b);
      logic rb;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, rb);
         b[i] = rb;
      end
      clk_bit(mack, rb);
   endtask

   // Write transfer of tx_bytes after a pointer byte; the model decides ACKs and writes.
   task automatic do_write(input logic [6:0] a, input logic [7:0] p);
      bit hit;
      hit = (a == DEV);
      bus_start();
      send_byte({a, 1'b0}, !hit, "addr_w");
      check("busy_after_addr", 32'(busy), 32'(hit));
      send_byte(p, !hit, "ptr");
      if (hit) model_ptr = p % NREG;
      foreach (tx_bytes[k]) begin
         if (hit) begin
            exp_wr.push_back('{a: 5'(model_ptr), d: tx_bytes[k]});
            model_ptr = (model_ptr + 1) % NREG;
         end
         send_byte(tx_bytes[k], !hit, "wdata");
      end
      bus_stop();
      #(4 * Q);
      check("busy_after_stop", 32'(busy), 32'd0);
      check("writes_drained", 32'(exp_wr.size()), 32'd0);
   endtask

`ifdef LEDCUBE_I2C_TARGET_READ_EN
   task automatic do_read(input logic [7:0] p, input int n);
      logic [7:0] got;
      rx_bytes.delete();
      bus_start();
      send_byte({DEV, 1'b0}, 1'b0, "addr_w");
      send_byte(p, 1'b0, "ptr");
      model_ptr = p % NREG;
      bus_start();
      send_byte({DEV, 1'b1}, 1'b0, "addr_r");
      for (int k = 0; k < n; k++) begin
         recv_byte((k == n - 1), got);
         check("rdata", 32'(got), 32'(model_regs[model_ptr]));
         rx_bytes.push_back(got);
         model_ptr = (model_ptr + 1) % NREG;
      end
      #Q;
      check("rd_released", 32'(sda_out), 32'd1);
      bus_stop();
      #(4 * Q);
   endtask
`else
   task automatic do_read_nack();
      bus_start();
      send_byte({DEV, 1'b1}, 1'b1, "addr_r_nack");
      send_byte(8'h00, 1'b1, "after_r_nack");
      check("r_nack_released", 32'(sda_out), 32'd1);
      bus_stop();
      #(4 * Q);
   endtask
`endif

   task automatic do_reset_mid_write();
      logic rb;
      bus_start();
      send_byte({DEV, 1'b0}, 1'b0, "rst_addr");
      send_byte(8'h0A, 1'b0, "rst_ptr");
      for (int i = 0; i < 3; i++) clk_bit(1'b1, rb);
      sda_m = 1'b0;
      #Q scl_m = 1'b1;
      #(Q / 2) reset = 1'b1;
      foreach (model_regs[i]) model_regs[i] = '0;
      exp_wr.delete();
      model_ptr = 0;
      #1;
      check("rst_sda_out", 32'(sda_out), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_valid", 32'(wr_valid), 32'd0);
      sda_m = 1'b1;
      #Q reset = 1'b0;
      #(2 * Q);
   endtask

   initial begin
      #32;
      check("reset_sda_out", 32'(sda_out), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_wr_valid", 32'(wr_valid), 32'd0);
      check("reset_wr_addr", 32'(wr_addr), 32'd0);
      check("reset_wr_data", 32'(wr_data), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         reg_rd_addr = 5'(i);
         #1 check("reset_regs", 32'(reg_rd_data), 32'd0);
      end
      foreach (model_regs[i]) model_regs[i] = '0;
      chk_en = 1'b1;
      #(4 * Q);

      // Basic write, with literal expectations pinning the model.
      tx_bytes = {8'hA5, 8'h3C};
      do_write(DEV, 8'h05);
      reg_rd_addr = 5'd6;
      #20 check("lit_reg6", 32'(reg_rd_data), 32'h3C);
      reg_rd_addr = 5'd5;
      #20 check("lit_reg5", 32'(reg_rd_data), 32'hA5);

`ifdef LEDCUBE_I2C_TARGET_READ_EN
      do_read(8'h05, 2);
      check("lit_rd0", 32'(rx_bytes[0]), 32'hA5);
      check("lit_rd1", 32'(rx_bytes[1]), 32'h3C);
`else
      do_read_nack();
`endif

      // Foreign address: no ACK, no writes, busy stays low.
      tx_bytes = {8'h99};
      do_write(7'h21, 8'h07);

      // Pointer wrap at the top of the register file.
      tx_bytes = {8'h11, 8'h22};
      do_write(DEV, 8'h1F);
      reg_rd_addr = 5'd31;
      #20 check("lit_wrap31", 32'(reg_rd_data), 32'h11);
      reg_rd_addr = 5'd0;
      #20 check("lit_wrap0", 32'(reg_rd_data), 32'h22);

      // Out-of-range pointer is reduced and still acknowledged.
      tx_bytes = {8'h5E};
      do_write(DEV, 8'hE3);
      reg_rd_addr = 5'd3;
      #20 check("lit_ptr_mod", 32'(reg_rd_data), 32'h5E);

      // Reset in the middle of the 4th data bit, then a clean write.
      do_reset_mid_write();
      tx_bytes = {8'h77};
      do_write(DEV, 8'h03);
      reg_rd_addr = 5'd3;
      #20 check("lit_after_reset", 32'(reg_rd_data), 32'h77);

      for (int t = 0; t < 22; t++) begin
         int kind;
         kind = $urandom_range(0, 3);
         reg_rd_addr = 5'($urandom_range(0, NREG - 1));
         if (kind < 3) begin
            logic [6:0] a;
            int         n;
            a = ($urandom_range(0, 1) == 0) ? DEV : 7'($urandom_range(0, 127));
            n = $urandom_range(1, 4);
            tx_bytes.delete();
            for (int k = 0; k < n; k++) tx_bytes.push_back(8'($urandom_range(0, 255)));
            do_write(a, 8'($urandom_range(0, 255)));
         end else begin
`ifdef LEDCUBE_I2C_TARGET_READ_EN
            do_read(8'($urandom_range(0, 255)), $urandom_range(1, 4));
`else
            do_read_nack();
`endif
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
